dram_cmd_responder: RTL and testbench
=====================================

DRAM_CMD_RESPONDER -- requirements
Module: dram_cmd_responder

Interface
REQ-001 SHALL have parameter NUM_OF_BANKS, default 8, number of banks; one-hot bank_sel width.
REQ-002 SHALL have parameter NUM_OF_ROWS, default 128, rows per bank; one-hot row_sel width.
REQ-003 SHALL have parameter NUM_OF_COLS, default 8, bit columns per row; one-hot col_sel width and burst length.
REQ-004 SHALL have parameter T_RCD, default 2, activate latency in cycles (minimum 1).
REQ-005 SHALL have parameter T_RFC, default 4, refresh busy time in cycles (minimum 1).
REQ-006 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-007 Ports: rst  in  1  reset, asynchronous, active-high.
REQ-008 Ports: cmd_req  in  1  level request from controller.
REQ-009 Ports: cmd  in  2  00 ACTIVATE, 01 READ, 10 WRITE, 11 REFRESH.
REQ-010 Ports: bank_sel  in  NUM_OF_BANKS  one-hot bank.
REQ-011 Ports: row_sel  in  NUM_OF_ROWS  one-hot row; used by ACTIVATE only.
REQ-012 Ports: col_sel  in  NUM_OF_COLS  one-hot start column; used by READ and WRITE.
REQ-013 Ports: dram_data_in  in  1  serial write bit.
REQ-014 Ports: dram_data_out  out  1  serial read bit; dram_data_oe  out  1  read drive enable.
REQ-015 Ports: cmd_ack  out  1  one-cycle completion pulse; cmd_err  out  1  one-cycle error pulse, coincident with cmd_ack.

Function
REQ-016 Storage SHALL be NUM_OF_BANKS x NUM_OF_ROWS rows of NUM_OF_COLS bits; each bank SHALL hold open_valid plus an open_row index.
REQ-017 FSM states SHALL be IDLE, ACT, RD, WR, REF, ACK, WAIT_REL.
REQ-018 In IDLE, when cmd_req=1, SHALL capture cmd and encoded bank/row/col in one cycle, then go to ACT, RD, WR or REF by cmd.
REQ-019 Error conditions: bank_sel not one-hot; ACTIVATE with row_sel not one-hot; READ/WRITE with col_sel not one-hot; READ/WRITE to a bank with open_valid=0.
REQ-020 On an error SHALL go directly to ACK with cmd_err=1 and SHALL change no storage, open-row state or data outputs.
REQ-021 ACT SHALL last T_RCD cycles, then set the bank's open_valid=1 and open_row=row, replacing any previously open row without error, then go to ACK.
REQ-022 RD SHALL last NUM_OF_COLS cycles with dram_data_oe=1, driving mem[bank][open_row][c] on cycle k, where c=(start+k) mod NUM_OF_COLS and k=0..NUM_OF_COLS-1.
REQ-023 WR SHALL last NUM_OF_COLS cycles, sampling dram_data_in into mem[bank][open_row][c] each cycle using the same wrap order as RD.
REQ-024 REF SHALL last T_RFC cycles, then clear open_valid in all banks (precharge-all), then go to ACK.
REQ-025 ACK SHALL last exactly 1 cycle with cmd_ack=1, then go to WAIT_REL.
REQ-026 WAIT_REL SHALL hold until cmd_req=0, then go to IDLE; a held request SHALL never be serviced twice.
REQ-027 Changes to cmd, bank_sel, row_sel and col_sel after capture SHALL be ignored until IDLE.
REQ-028 When not in RD, dram_data_oe SHALL be 0 and dram_data_out SHALL be 0.
REQ-029 Column counter SHALL be log2(NUM_OF_COLS) bits and wrap naturally; burst counter SHALL count 0..NUM_OF_COLS-1.
REQ-030 Dropping cmd_req mid-operation SHALL NOT abort the operation; cmd_ack SHALL still pulse and the FSM SHALL then pass through WAIT_REL to IDLE.

Reset
REQ-031 rst=1 SHALL immediately force IDLE and clear cmd_ack, cmd_err, dram_data_oe, dram_data_out, all counters and all open_valid bits.
REQ-032 Storage array contents SHALL NOT be reset; a read of an unwritten location returns an undefined value.
REQ-033 Reset during RD, WR, ACT or REF SHALL abandon the operation without cmd_ack; a partially written row keeps the bits already written.

Verification
REQ-034 Round trip: ACTIVATE bank 2 / row 5, WRITE col_sel=0x01 with data bits 1,0,1,1,0,0,1,0, then READ col_sel=0x01 -> same 8 bits returned in order, dram_data_oe high exactly 8 cycles, 3 cmd_ack pulses, cmd_err=0.
REQ-035 Wrap-around: READ of the same row with col_sel=0x40 -> bits for columns 6,7,0,1,...,5 returned in that order.
REQ-036 Closed bank: READ to bank 3 right after reset -> cmd_ack and cmd_err high on the same cycle, dram_data_oe stays 0; REFRESH then READ bank 2 -> cmd_err=1.
REQ-037 Illegal select: bank_sel=0x03 with ACTIVATE -> cmd_err=1, and a following READ of bank 0 or bank 1 still errors.
REQ-038 Handshake: hold cmd_req high 20 cycles for ACTIVATE -> cmd_ack one cycle, exactly T_RCD+2 cycles after the request is sampled, and no second ack; ACTIVATE ack latency =T_RCD+2 and REFRESH ack latency =T_RFC+2.
REQ-039 Reset mid-WR after 4 bits -> outputs cleared asynchronously, no cmd_ack; next READ errors because the bank is closed.

Source files
------------

// File: rtl/dram_cmd_responder.sv
// DRAM command responder: services ACTIVATE / READ / WRITE / REFRESH
// requests from a level-sensitive controller handshake, keeps one open row
// per bank and streams a row's bits serially starting at any column.
//
// Handshake: the controller raises cmd_req and holds cmd/bank/row/col stable
// until the request is captured (the IDLE cycle that sees cmd_req=1). The
// responder pulses cmd_ack (with cmd_err on failures) for exactly one cycle
// when the command completes, and will not accept a new command until
// cmd_req has been seen low.
//
// NUM_OF_COLS must be a power of two so the column counter wraps naturally.
module dram_cmd_responder #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RCD        = 2,
    parameter int T_RFC        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_req,
    input  logic [1:0]              cmd,
    input  logic [NUM_OF_BANKS-1:0] bank_sel,
    input  logic [NUM_OF_ROWS-1:0]  row_sel,
    input  logic [NUM_OF_COLS-1:0]  col_sel,
    input  logic                    dram_data_in,
    output logic                    dram_data_out,
    output logic                    dram_data_oe,
    output logic                    cmd_ack,
    output logic                    cmd_err
);

    localparam int BW   = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
    localparam int RW   = (NUM_OF_ROWS  > 1) ? $clog2(NUM_OF_ROWS)  : 1;
    localparam int CW   = (NUM_OF_COLS  > 1) ? $clog2(NUM_OF_COLS)  : 1;
    localparam int TMAX = (T_RCD > T_RFC) ? T_RCD : T_RFC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_REF = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT,
        S_RD,
        S_WR,
        S_REF,
        S_ACK,
        S_WAIT_REL
    } state_t;

    state_t                  state_q, state_d;
    logic [BW-1:0]           bank_q, bank_d;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [CW-1:0]           burst_q, burst_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic                    err_q, err_d;
    logic [NUM_OF_BANKS-1:0] open_valid_q, open_valid_d;
    logic [RW-1:0]           open_row_q [NUM_OF_BANKS];
    logic [RW-1:0]           open_row_d [NUM_OF_BANKS];

    // Storage is intentionally never reset.
    logic [NUM_OF_COLS-1:0]  mem [NUM_OF_BANKS][NUM_OF_ROWS];

    logic [BW-1:0] bank_idx;
    logic [RW-1:0] row_idx;
    logic [CW-1:0] col_idx;
    logic          req_err;
    logic          mem_we;

    // One-hot to binary encoders for the request selects (meaningful only when one-hot).
    always_comb begin
        bank_idx = '0;
        row_idx  = '0;
        col_idx  = '0;
        for (int i = 0; i < NUM_OF_BANKS; i++) if (bank_sel[i]) bank_idx = BW'(i);
        for (int i = 0; i < NUM_OF_ROWS;  i++) if (row_sel[i])  row_idx  = RW'(i);
        for (int i = 0; i < NUM_OF_COLS;  i++) if (col_sel[i])  col_idx  = CW'(i);
    end

    // Request legality: bad selects, or column access to a bank with no open row.
    always_comb begin
        req_err = 1'b0;
        if (!$onehot(bank_sel)) begin
            req_err = 1'b1;
        end else if (cmd == CMD_ACT) begin
            req_err = !$onehot(row_sel);
        end else if (cmd == CMD_RD || cmd == CMD_WR) begin
            req_err = !$onehot(col_sel) || !open_valid_q[bank_idx];
        end
    end

    // Next-state and datapath updates for the command FSM.
    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        row_d        = row_q;
        col_d        = col_q;
        burst_d      = burst_q;
        tmr_d        = tmr_q;
        err_d        = err_q;
        open_valid_d = open_valid_q;
        open_row_d   = open_row_q;
        mem_we       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (cmd_req) begin
                    bank_d  = bank_idx;
                    row_d   = row_idx;
                    col_d   = col_idx;
                    burst_d = '0;
                    tmr_d   = '0;
                    if (req_err) begin
                        err_d   = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        unique case (cmd)
                            CMD_ACT: state_d = S_ACT;
                            CMD_RD:  state_d = S_RD;
                            CMD_WR:  state_d = S_WR;
                            default: state_d = S_REF;
                        endcase
                    end
                end
            end
            S_ACT: begin
                if (tmr_q == TW'(T_RCD - 1)) begin
                    open_valid_d[bank_q] = 1'b1;
                    open_row_d[bank_q]   = row_q;
                    state_d              = S_ACK;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RD, S_WR: begin
                mem_we  = (state_q == S_WR);
                col_d   = col_q + 1'b1;
                burst_d = burst_q + 1'b1;
                if (burst_q == CW'(NUM_OF_COLS - 1)) state_d = S_ACK;
            end
            S_REF: begin
                if (tmr_q == TW'(T_RFC - 1)) begin
                    open_valid_d = '0;
                    state_d      = S_ACK;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!cmd_req) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and open-row state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bank_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            burst_q      <= '0;
            tmr_q        <= '0;
            err_q        <= 1'b0;
            open_valid_q <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) open_row_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            row_q        <= row_d;
            col_q        <= col_d;
            burst_q      <= burst_d;
            tmr_q        <= tmr_d;
            err_q        <= err_d;
            open_valid_q <= open_valid_d;
            open_row_q   <= open_row_d;
        end
    end

    // Serial write into the open row; reset forces IDLE so no write happens under reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[bank_q][open_row_q[bank_q]][col_q] <= dram_data_in;
    end

    // Outputs decode directly from state, so reset clears them without waiting for a clock.
    always_comb begin
        dram_data_oe  = (state_q == S_RD);
        dram_data_out = dram_data_oe & mem[bank_q][open_row_q[bank_q]][col_q];
        cmd_ack       = (state_q == S_ACK);
        cmd_err       = cmd_ack & err_q;
    end

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Self-checking bench for dram_cmd_responder: directed scenarios followed by
// random command traffic, all checked against a behavioural model of the
// bank/row/column storage and the command timing rules.
module tb_dram_cmd_responder;
  localparam int NB   = 8;
  localparam int NR   = 128;
  localparam int NC   = 8;
  localparam int TRCD = 2;
  localparam int TRFC = 4;

  localparam logic [1:0] C_ACT = 2'b00;
  localparam logic [1:0] C_RD  = 2'b01;
  localparam logic [1:0] C_WR  = 2'b10;
  localparam logic [1:0] C_REF = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_req;
  logic [1:0]    cmd;
  logic [NB-1:0] bank_sel;
  logic [NR-1:0] row_sel;
  logic [NC-1:0] col_sel;
  logic          dram_data_in;
  logic          dram_data_out;
  logic          dram_data_oe;
  logic          cmd_ack;
  logic          cmd_err;

  dram_cmd_responder #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
    .T_RCD(TRCD), .T_RFC(TRFC)
  ) dut (
    .clk(clk), .rst(rst), .cmd_req(cmd_req), .cmd(cmd),
    .bank_sel(bank_sel), .row_sel(row_sel), .col_sel(col_sel),
    .dram_data_in(dram_data_in), .dram_data_out(dram_data_out),
    .dram_data_oe(dram_data_oe), .cmd_ack(cmd_ack), .cmd_err(cmd_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_open  [NB];
  int          m_row   [NB];
  bit [NC-1:0] m_mem   [NB][NR];
  bit [NC-1:0] m_known [NB][NR];

  function automatic int lowest_bit(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_close_all();
    for (int i = 0; i < NB; i++) m_open[i] = 1'b0;
  endtask

  // ---------------- observation of one command ----------------
  int          r_ack_at;
  int          r_acks;
  bit          r_err;
  int          r_oe_cycles;
  logic [NC-1:0] r_rd;
  bit          r_leak;
  bit          r_stray_err;

  // Cycle 1 is the cycle in which the request is presented and sampled;
  // the DUT samples write bit k at the end of cycle k+2.
  task automatic run_cmd(input logic [1:0] c, input logic [NB-1:0] b, input logic [NR-1:0] r,
                         input logic [NC-1:0] s, input logic [NC-1:0] wd,
                         input int hold_extra, input bit drop_early);
    int cyc;
    bit done;
    cmd = c; bank_sel = b; row_sel = r; col_sel = s; dram_data_in = 1'b0;
    cmd_req = 1'b1;
    r_ack_at = 0; r_acks = 0; r_err = 1'b0; r_oe_cycles = 0; r_rd = '0;
    r_leak = 1'b0; r_stray_err = 1'b0;
    cyc = 1; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      // selects are scrambled after capture and must have no effect
      cmd = 2'($urandom); bank_sel = NB'($urandom);
      row_sel = {4{$urandom}}; col_sel = NC'($urandom);
      if (cyc - 2 >= 0 && cyc - 2 < NC) dram_data_in = wd[cyc-2];
      else dram_data_in = 1'($urandom_range(0, 1));
      if (drop_early && cyc == 3) cmd_req = 1'b0;
      if (dram_data_oe) begin
        if (r_oe_cycles < NC) r_rd[r_oe_cycles] = dram_data_out;
        r_oe_cycles++;
      end else if (dram_data_out !== 1'b0) r_leak = 1'b1;
      if (cmd_ack) begin
        r_acks++;
        if (r_ack_at == 0) begin r_ack_at = cyc; r_err = cmd_err; end
      end else if (cmd_err) r_stray_err = 1'b1;
      if (r_ack_at != 0 && cyc >= r_ack_at + hold_extra) done = 1'b1;
    end
    check_eq("ack_seen", 64'(r_ack_at != 0), 64'd1);
    cmd_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cmd_ack) r_acks++;
      if (dram_data_oe) r_oe_cycles++;
      else if (dram_data_out !== 1'b0) r_leak = 1'b1;
    end
  endtask

  // Computes expectations from the model, runs the command, checks, updates the model.
  task automatic do_cmd(input string tag, input logic [1:0] c, input logic [NB-1:0] b,
                        input logic [NR-1:0] r, input logic [NC-1:0] s, input logic [NC-1:0] wd,
                        input int hold_extra, input bit drop_early);
    bit exp_err;
    int exp_lat, exp_oe, bi, ri, si, row;
    logic [NC-1:0] exp_rd, mask;
    bi = lowest_bit(NR'(b)); ri = lowest_bit(r); si = lowest_bit(NR'(s));
    exp_err = !$onehot(b) || (c == C_ACT && !$onehot(r)) ||
              ((c == C_RD || c == C_WR) && (!$onehot(s) || !m_open[bi]));
    if (exp_err) exp_lat = 2;
    else if (c == C_ACT) exp_lat = TRCD + 2;
    else if (c == C_REF) exp_lat = TRFC + 2;
    else exp_lat = NC + 2;
    exp_oe = (!exp_err && c == C_RD) ? NC : 0;
    exp_rd = '0; mask = '0;
    row = m_row[bi];
    if (exp_oe != 0) begin
      for (int k = 0; k < NC; k++) begin
        exp_rd[k] = m_mem[bi][row][(si + k) % NC];
        mask[k]   = m_known[bi][row][(si + k) % NC];
      end
    end
    run_cmd(c, b, r, s, wd, hold_extra, drop_early);
    check_eq({tag, "_lat"},   64'(r_ack_at), 64'(exp_lat));
    check_eq({tag, "_acks"},  64'(r_acks), 64'd1);
    check_eq({tag, "_err"},   64'(r_err), 64'(exp_err));
    check_eq({tag, "_oe"},    64'(r_oe_cycles), 64'(exp_oe));
    check_eq({tag, "_quiet"}, 64'({r_leak, r_stray_err}), 64'd0);
    if (mask != '0) check_eq({tag, "_rdata"}, 64'(r_rd & mask), 64'(exp_rd & mask));
    if (!exp_err) begin
      case (c)
        C_ACT: begin m_open[bi] = 1'b1; m_row[bi] = ri; end
        C_WR: begin
          for (int k = 0; k < NC; k++) begin
            m_mem[bi][row][(si + k) % NC]   = wd[k];
            m_known[bi][row][(si + k) % NC] = 1'b1;
          end
        end
        C_REF: model_close_all();
        default: ;
      endcase
    end
  endtask

  // Starts a READ or WRITE and asserts reset in cycle rst_cyc.
  task automatic run_with_reset(input string tag, input logic [1:0] c, input logic [NB-1:0] b,
                                input logic [NC-1:0] s, input logic [NC-1:0] wd, input int rst_cyc);
    int bi, si, acks;
    bi = lowest_bit(NR'(b)); si = lowest_bit(NR'(s));
    cmd = c; bank_sel = b; row_sel = '0; col_sel = s; cmd_req = 1'b1;
    for (int cyc = 2; cyc <= rst_cyc; cyc++) begin
      @(negedge clk);
      if (cyc < rst_cyc) dram_data_in = wd[cyc-2];
    end
    if (c == C_RD) check_eq({tag, "_oe_before"}, 64'(dram_data_oe), 64'd1);
    rst = 1'b1;
    #1;
    check_eq({tag, "_oe_async"},  64'(dram_data_oe), 64'd0);
    check_eq({tag, "_out_async"}, 64'(dram_data_out), 64'd0);
    check_eq({tag, "_ack_async"}, 64'({cmd_ack, cmd_err}), 64'd0);
    cmd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (cmd_ack) acks++;
    end
    check_eq({tag, "_no_ack"}, 64'(acks), 64'd0);
    if (c == C_WR) begin
      for (int k = 0; k < rst_cyc - 2; k++) begin
        m_mem[bi][m_row[bi]][(si + k) % NC]   = wd[k];
        m_known[bi][m_row[bi]][(si + k) % NC] = 1'b1;
      end
    end
    model_close_all();
  endtask

  function automatic logic [NR-1:0] row_oh(input int i);
    logic [NR-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [NC-1:0] wd;
    logic [1:0]    rc;
    logic [NB-1:0] rb;
    logic [NC-1:0] rs;
    logic [NR-1:0] rr;
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0; m_row[i] = 0;
      for (int j = 0; j < NR; j++) begin m_mem[i][j] = '0; m_known[i][j] = '0; end
    end
    rst = 1'b1; cmd_req = 1'b0; cmd = '0; bank_sel = '0; row_sel = '0; col_sel = '0;
    dram_data_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_oe",  64'(dram_data_oe), 64'd0);
    check_eq("rst_out", 64'(dram_data_out), 64'd0);
    check_eq("rst_ack", 64'({cmd_ack, cmd_err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // closed bank right after reset
    do_cmd("rd_closed", C_RD, 8'h08, '0, 8'h01, '0, 0, 1'b0);
    // round trip with a long-held request
    do_cmd("act_hold", C_ACT, 8'h04, row_oh(5), '0, '0, 16, 1'b0);
    do_cmd("wr_rt", C_WR, 8'h04, '0, 8'h01, 8'b0100_1101, 0, 1'b0);
    do_cmd("rd_rt", C_RD, 8'h04, '0, 8'h01, '0, 0, 1'b0);
    check_eq("rd_rt_bits", 64'(r_rd), 64'h4D);
    do_cmd("rd_wrap", C_RD, 8'h04, '0, 8'h40, '0, 2, 1'b0);
    check_eq("rd_wrap_bits", 64'(r_rd), 64'h35);
    // refresh closes everything
    do_cmd("ref_hold", C_REF, 8'h01, '0, '0, '0, 10, 1'b0);
    do_cmd("rd_after_ref", C_RD, 8'h04, '0, 8'h01, '0, 0, 1'b0);
    // illegal selects
    do_cmd("act_badbank", C_ACT, 8'h03, row_oh(1), '0, '0, 0, 1'b0);
    do_cmd("rd_bank0", C_RD, 8'h01, '0, 8'h01, '0, 0, 1'b0);
    do_cmd("rd_bank1", C_RD, 8'h02, '0, 8'h01, '0, 0, 1'b0);
    do_cmd("act_badrow", C_ACT, 8'h01, row_oh(1) | row_oh(9), '0, '0, 0, 1'b0);
    do_cmd("wr_badcol", C_WR, 8'h04, '0, 8'h00, 8'hFF, 0, 1'b0);
    // request dropped mid-operation still completes
    do_cmd("act_drop", C_ACT, 8'h04, row_oh(5), '0, '0, 0, 1'b1);
    do_cmd("wr_drop", C_WR, 8'h04, '0, 8'h10, 8'hA6, 0, 1'b1);
    do_cmd("rd_drop", C_RD, 8'h04, '0, 8'h01, '0, 0, 1'b0);
    // reset mid-WR after 4 bits, then mid-RD
    do_cmd("act_pre", C_ACT, 8'h04, row_oh(5), '0, '0, 0, 1'b0);
    run_with_reset("rst_wr", C_WR, 8'h04, 8'h04, 8'b0011_0110, 6);
    do_cmd("rd_after_rst", C_RD, 8'h04, '0, 8'h01, '0, 0, 1'b0);
    do_cmd("act_again", C_ACT, 8'h04, row_oh(5), '0, '0, 0, 1'b0);
    do_cmd("rd_partial", C_RD, 8'h04, '0, 8'h04, '0, 0, 1'b0);
    run_with_reset("rst_rd", C_RD, 8'h04, 8'h01, '0, 4);

    // random traffic
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rc = C_ACT;
        3, 4, 5: rc = C_WR;
        9:       rc = C_REF;
        default: rc = C_RD;
      endcase
      rb = ($urandom_range(0, 9) == 0) ? NB'($urandom) : NB'(1) << $urandom_range(0, NB - 1);
      rs = ($urandom_range(0, 9) == 0) ? NC'($urandom) : NC'(1) << $urandom_range(0, NC - 1);
      rr = ($urandom_range(0, 19) == 0) ? (row_oh(2) | row_oh(70)) : row_oh($urandom_range(0, 7));
      wd = NC'($urandom);
      do_cmd("rand", rc, rb, rr, rs, wd, $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end
endmodule
